// File: rtl/trng_word_collector.sv
// trng_word_collector: decimates a synchronised ring-oscillator bit stream,
// debiases it with a von Neumann corrector, packs WIDTH-bit words for a
// valid/ready consumer and runs a sticky repetition-count health test.
module trng_word_collector #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_bit,
  input  logic             enable,
  input  logic             clear_fail,
  output logic [WIDTH-1:0] rnd_word,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             health_fail
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FAIL    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pair_q, pair_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             fail_q, fail_d;

  logic             tick;
  logic [CNT_W-1:0] cnt_inc;

  // Sample strobe: only while enabled and actively collecting.
  assign tick = enable && (state_q == ST_COLLECT) && (div_q == DIV_MAX);

  // Next-state logic: divider, health test, corrector, packer, FSM, handshake.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pair_d    = pair_q;
    first_d   = first_q;
    last_d    = last_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    word_d    = word_q;
    valid_d   = valid_q;
    fail_d    = fail_q;
    cnt_inc   = bit_cnt_q + CNT_W'(1);

    // Divider is cleared by enable=0 and frozen outside COLLECT.
    if (!enable) begin
      div_d = '0;
    end else if (state_q == ST_COLLECT) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Consumer takes the presented word; a DRAIN transfer below may reload.
    if (valid_q && rnd_ready) valid_d = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (tick) begin
          // Repetition count runs on every raw sample, independent of pairing.
          if ((rep_q != '0) && (raw_bit == last_q))
            rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + REP_W'(1);
          else
            rep_d = REP_W'(1);
          last_d = raw_bit;

          if (rep_d == REP_MAX) begin
            // Failure beats a simultaneously completed word: drop the partial.
            fail_d    = 1'b1;
            bit_cnt_d = '0;
            pair_d    = 1'b0;
            state_d   = ST_FAIL;
          end else if (!pair_q) begin
            first_d = raw_bit;
            pair_d  = 1'b1;
          end else begin
            pair_d = 1'b0;
            // Unequal pair emits its first bit; 00/11 emit nothing.
            if (first_q != raw_bit) begin
              shreg_d   = {shreg_q[WIDTH-2:0], first_q};
              bit_cnt_d = cnt_inc;
              if (cnt_inc == WIDTH_C) state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        // Move the assembled word out as soon as the slot is (or becomes) free.
        if (!valid_q || rnd_ready) begin
          word_d    = shreg_q;
          valid_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_COLLECT;
        end
      end
      ST_FAIL: begin
        if (clear_fail) begin
          fail_d  = 1'b0;
          rep_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      div_q     <= '0;
      pair_q    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pair_q    <= pair_d;
      first_q   <= first_d;
      last_q    <= last_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      fail_q    <= fail_d;
    end
  end

  assign rnd_word    = word_q;
  assign rnd_valid   = valid_q;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_word_collector.sv
// Scoreboard bench for trng_word_collector: expected words are queued as the
// bits are driven; the handshake monitor collects accepted words for popping.
module tb_trng_word_collector;
  localparam int WIDTH      = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int REP_LIMIT  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             raw_bit = 1'b0;
  logic             enable = 1'b0;
  logic             clear_fail = 1'b0;
  logic             rnd_ready = 1'b0;
  logic [WIDTH-1:0] rnd_word;
  logic             rnd_valid;
  logic             health_fail;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  always #5 clk = ~clk;

  trng_word_collector #(.WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .enable(enable),
    .clear_fail(clear_fail), .rnd_word(rnd_word), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .health_fail(health_fail)
  );

  // Capture every word the consumer accepts.
  always @(negedge clk)
    if (rst_n && rnd_valid && rnd_ready) got_q.push_back(rnd_word);

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One raw sample, aligned so the tick lands on the last cycle of the window.
  task automatic sample(input logic b);
    raw_bit = b;
    cyc(SAMPLE_DIV);
  endtask

  // Pair (b, ~b) makes the corrector emit b.
  task automatic send_bit(input logic b);
    sample(b);
    sample(~b);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (rnd_word !== '0 || rnd_valid !== 1'b0 || health_fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_during word=%h valid=%b fail=%b want 0/0/0", rnd_word, rnd_valid, health_fail);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (rnd_word !== '0 || rnd_valid !== 1'b0 || health_fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_after word=%h valid=%b fail=%b want 0/0/0", rnd_word, rnd_valid, health_fail);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] e;
    rnd_ready = 1'b1;
    enable = 1'b1;
    exp_q.push_back(8'hB2);
    send_word(8'hB2, 7, 0);
    enable = 1'b0;
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL lat_drain valid=%b want 0", rnd_valid); end
    cyc(1);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_word !== 8'hB2) begin
      errors++; $display("FAIL lat_valid valid=%b word=%h want 1/b2", rnd_valid, rnd_word);
    end
    cyc(1);
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle valid=%b want 0", rnd_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL basic_word got none want %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL basic_word got %h want %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
  endtask

  task automatic test_discard_pairs();
    logic [WIDTH-1:0] e;
    rnd_ready = 1'b1;
    enable = 1'b1;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < WIDTH; i++) begin
      sample(i[0]); sample(i[0]);   // 00 or 11: dropped
      send_bit(1'b1);
    end
    enable = 1'b0;
    cyc(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL discard_word got none want %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL discard_word got %h want %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL discard_extra got %0d extra words want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] e;
    rnd_ready = 1'b0;
    enable = 1'b1;
    exp_q.push_back(8'hB2);
    send_word(8'hB2, 7, 0);
    enable = 1'b0;
    cyc(3);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_word !== 8'hB2) begin
      errors++; $display("FAIL bp_first valid=%b word=%h want 1/b2", rnd_valid, rnd_word);
    end
    enable = 1'b1;
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 7, 0);
    enable = 1'b0;
    cyc(5);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_word !== 8'hB2) begin
      errors++; $display("FAIL bp_hold valid=%b word=%h want 1/b2", rnd_valid, rnd_word);
    end
    rnd_ready = 1'b1;
    cyc(1);
    rnd_ready = 1'b0;
    checks++;
    if (rnd_valid !== 1'b1 || rnd_word !== 8'hFF) begin
      errors++; $display("FAIL bp_reload valid=%b word=%h want 1/ff", rnd_valid, rnd_word);
    end
    cyc(2);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_word !== 8'hFF) begin
      errors++; $display("FAIL bp_stable valid=%b word=%h want 1/ff", rnd_valid, rnd_word);
    end
    rnd_ready = 1'b1;
    cyc(1);
    rnd_ready = 1'b0;
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed valid=%b want 0", rnd_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL bp_word got none want %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL bp_word got %h want %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
  endtask

  task automatic test_health();
    logic [WIDTH-1:0] e;
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
    rnd_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < REP_LIMIT - 1; i++) sample(1'b1);
    checks++;
    if (health_fail !== 1'b0) begin errors++; $display("FAIL hf_early fail=%b want 0", health_fail); end
    sample(1'b1);
    checks++;
    if (health_fail !== 1'b1) begin errors++; $display("FAIL hf_trip fail=%b want 1", health_fail); end
    cyc(10);
    checks++;
    if (health_fail !== 1'b1 || rnd_valid !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL hf_sticky fail=%b valid=%b words=%0d want 1/0/0", health_fail, rnd_valid, got_q.size());
    end
    enable = 1'b0;
    clear_fail = 1'b1; cyc(1); clear_fail = 1'b0;
    checks++;
    if (health_fail !== 1'b0) begin errors++; $display("FAIL hf_clear fail=%b want 0", health_fail); end
    enable = 1'b1;
    for (int i = 0; i < REP_LIMIT - 1; i++) sample(1'b1);
    checks++;
    if (health_fail !== 1'b0) begin errors++; $display("FAIL hf_rep_restart fail=%b want 0", health_fail); end
    sample(1'b1);
    checks++;
    if (health_fail !== 1'b1) begin errors++; $display("FAIL hf_retrip fail=%b want 1", health_fail); end
    enable = 1'b0;
    clear_fail = 1'b1; cyc(1); clear_fail = 1'b0;
    enable = 1'b1;
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 7, 0);
    enable = 1'b0;
    cyc(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL hf_resume_word got none want %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL hf_resume_word got %h want %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
  endtask

  task automatic test_enable_gap();
    logic [WIDTH-1:0] e;
    rnd_ready = 1'b1;
    enable = 1'b1;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 7, 5);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin raw_bit = i[0]; cyc(1); end
    checks++;
    if (rnd_valid !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL en_gap valid=%b words=%0d want 0/0", rnd_valid, got_q.size());
    end
    enable = 1'b1;
    send_word(8'h5A, 4, 0);
    enable = 1'b0;
    cyc(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL en_word got none want %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL en_word got %h want %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] e;
    rnd_ready = 1'b1;
    enable = 1'b1;
    send_word(8'hFF, 7, 5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rnd_word !== '0 || rnd_valid !== 1'b0 || health_fail !== 1'b0) begin
      errors++; $display("FAIL rst_mid word=%h valid=%b fail=%b want 0/0/0", rnd_word, rnd_valid, health_fail);
    end
    enable = 1'b0;
    cyc(1); rst_n = 1'b1; cyc(1);
    enable = 1'b1;
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 7, 1);
    enable = 1'b0;
    cyc(4);
    checks++;
    if (rnd_valid !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL rst_no_early valid=%b words=%0d want 0/0", rnd_valid, got_q.size());
    end
    enable = 1'b1;
    send_word(8'h3C, 0, 0);
    enable = 1'b0;
    cyc(3);
    rnd_ready = 1'b0;
    enable = 1'b1;
    send_word(8'hA5, 7, 0);
    enable = 1'b0;
    cyc(3);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_word !== 8'hA5) begin
      errors++; $display("FAIL rst_pre_valid valid=%b word=%h want 1/a5", rnd_valid, rnd_word);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rnd_word !== '0 || rnd_valid !== 1'b0 || health_fail !== 1'b0) begin
      errors++; $display("FAIL rst_valid word=%h valid=%b fail=%b want 0/0/0", rnd_word, rnd_valid, health_fail);
    end
    cyc(1); rst_n = 1'b1; cyc(1);
    rnd_ready = 1'b1;
    enable = 1'b1;
    exp_q.push_back(8'hC3);
    send_word(8'hC3, 7, 0);
    enable = 1'b0;
    cyc(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL rst_word got none want %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL rst_word got %h want %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL rst_extra got %0d extra words want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discard_pairs();
    test_backpressure();
    test_health();
    test_enable_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
